// File: rtl/alu_multicycle.sv
`default_nettype none
// alu_multicycle: registered ALU with single-cycle logic/arith ops plus iterative
// shift-add MULU and restoring DIVU behind a Start/Busy/Done handshake.
module alu_multicycle #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             carry_o,
    output logic             divzero_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    localparam logic [2:0]       OP_AND = 3'b000;
    localparam logic [2:0]       OP_OR  = 3'b001;
    localparam logic [2:0]       OP_ADD = 3'b010;
    localparam logic [2:0]       OP_SUB = 3'b011;
    localparam logic [2:0]       OP_SLT = 3'b100;
    localparam logic [2:0]       OP_SLL = 3'b101;
    localparam logic [WIDTH-1:0] C_WIDTH_V = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_q, div_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               carry_q, carry_d;
    logic               divz_q, divz_d;

    logic [WIDTH:0]     w_add, w_sub;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf, w_carry;
    logic [WIDTH:0]     w_mul_sum, w_div_shift, w_it_acc;
    logic [WIDTH-1:0]   w_it_lo;
    logic               w_div_ge;
    logic               w_accept;

    assign w_add = {1'b0, a_i} + {1'b0, b_i};
    assign w_sub = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_res   = '0;
        w_ovf   = 1'b0;
        w_carry = 1'b0;
        case (op_i)
            OP_AND: w_res = a_i & b_i;
            OP_OR:  w_res = a_i | b_i;
            OP_ADD: begin
                w_res   = w_add[WIDTH-1:0];
                w_carry = w_add[WIDTH];
                w_ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (w_add[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                w_res   = w_sub[WIDTH-1:0];
                w_carry = w_sub[WIDTH];
                w_ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (w_sub[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLL: w_res = (b_i >= C_WIDTH_V) ? '0 : (a_i << b_i[CNT_W-1:0]);
            default: w_res = '0;
        endcase
    end

    // One iteration of either engine; {acc, lo} forms the working register pair.
    assign w_mul_sum   = lo_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;
    assign w_div_shift = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, mcand_q});

    always_comb begin
        if (div_q) begin
            w_it_acc = w_div_ge ? (w_div_shift - {1'b0, mcand_q}) : w_div_shift;
            w_it_lo  = {lo_q[WIDTH-2:0], w_div_ge};
        end else begin
            w_it_acc = {1'b0, w_mul_sum[WIDTH:1]};
            w_it_lo  = {w_mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign w_accept = start_i && (state_q != S_CALC);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        carry_d  = carry_q;
        divz_d   = divz_q;

        if (state_q == S_CALC) begin
            acc_d = w_it_acc;
            lo_d  = w_it_lo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == C_LAST) begin
                // A zero divisor makes every compare succeed: quotient all ones and
                // the whole dividend ends up shifted into the remainder.
                result_d = w_it_lo;
                hi_d     = w_it_acc[WIDTH-1:0];
                zero_d   = (w_it_lo == '0);
                ovf_d    = !div_q && (w_it_acc[WIDTH-1:0] != '0);
                carry_d  = 1'b0;
                divz_d   = div_q && (mcand_q == '0);
                state_d  = S_FIN;
            end
        end else if (w_accept) begin
            if (op_i[2:1] == 2'b11) begin
                div_d   = op_i[0];
                mcand_d = b_i;
                lo_d    = a_i;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_CALC;
            end else begin
                result_d = w_res;
                hi_d     = '0;
                zero_d   = (w_res == '0);
                ovf_d    = w_ovf;
                carry_d  = w_carry;
                divz_d   = 1'b0;
                state_d  = S_FIN;
            end
        end else if (state_q == S_FIN) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            carry_q  <= 1'b0;
            divz_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            carry_q  <= carry_d;
            divz_q   <= divz_d;
        end
    end

    assign busy_o     = (state_q == S_CALC);
    assign done_o     = (state_q == S_FIN);
    assign result_o   = result_q;
    assign hi_o       = hi_q;
    assign zero_o     = zero_q;
    assign overflow_o = ovf_q;
    assign carry_o    = carry_q;
    assign divzero_o  = divz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// tb_alu_multicycle: directed vectors; a driver queues expected responses and a
// monitor compares them against each Done pulse, including its arrival cycle.
module tb_alu_multicycle;

    localparam int W = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op = 3'b000;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy, done, zero, ovf, carry, divz;
    logic [W-1:0]  result, hi;

    alu_multicycle #(.WIDTH(W), .CNT_W(5)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .busy_o(busy), .done_o(done), .result_o(result), .hi_o(hi),
        .zero_o(zero), .overflow_o(ovf), .carry_o(carry), .divzero_o(divz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [51:0] v;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    task automatic issue(input string nm, input logic [2:0] o, input logic [W-1:0] aa,
                         input logic [W-1:0] bb, input logic [W-1:0] r, input logic [W-1:0] h,
                         input logic z, input logic v, input logic c, input logic d);
        int n = 0;
        exp_t e;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({nm, "_busy_timeout"}, {63'd0, busy}, 64'd0);
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        e.name = nm;
        e.v    = {r, h, z, v, c, d};
        e.cyc  = cyc + 1 + ((o[2:1] == 2'b11) ? W : 0);
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    e = q.pop_front();
                    check(e.name, {12'd0, result, hi, zero, ovf, carry, divz}, {12'd0, e.v});
                    check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : driver
        int bc;
        int n;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("reset_outputs", {10'd0, busy, done, result, hi, zero, ovf, carry, divz}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue("add_ovf",  3'b010, 24'h7FFFFF, 24'h000001, 24'h800000, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        issue("sub_zero", 3'b011, 24'h00ABCD, 24'h00ABCD, 24'h000000, 24'h0, 1'b1, 1'b0, 1'b1, 1'b0);

        // MULU abandoned by an asynchronous reset five cycles in.
        @(negedge clk);
        start = 1'b1; op = 3'b110; a = 24'h000123; b = 24'h000456;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_mulu", {10'd0, busy, done, result, hi, zero, ovf, carry, divz}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        issue("add_after_rst", 3'b010, 24'h000005, 24'h000003, 24'h000008, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("and",  3'b000, 24'hF0F0F0, 24'h0FF0FF, 24'h00F0F0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("or",   3'b001, 24'hF00000, 24'h00000F, 24'hF0000F, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("sub_borrow", 3'b011, 24'h000000, 24'h000001, 24'hFFFFFF, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("sub_ovf", 3'b011, 24'h800000, 24'h000001, 24'h7FFFFF, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0);

        issue("mulu_full", 3'b110, 24'hFFFFFF, 24'hFFFFFF, 24'h000001, 24'hFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0);
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            @(negedge clk);
        end
        check("mulu_busy_cycles", 64'(bc), 64'd24);

        issue("divu",      3'b111, 24'h0003E8, 24'h000007, 24'h00008E, 24'h000006, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("divu_zero", 3'b111, 24'h123456, 24'h000000, 24'hFFFFFF, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b1);
        issue("slt_neg",   3'b100, 24'h800000, 24'h000001, 24'h000001, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("slt_ovf",   3'b100, 24'h7FFFFF, 24'h800000, 24'h000000, 24'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue("sll_23",    3'b101, 24'h000001, 24'h000017, 24'h800000, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("sll_24",    3'b101, 24'h000001, 24'h000018, 24'h000000, 24'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Start pulse and operand changes during CALC must not disturb the MULU.
        issue("mulu_ignore_start", 3'b110, 24'h000003, 24'h000005, 24'h00000F, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 3'b010; a = 24'h000001; b = 24'h000001;
        @(negedge clk);
        start = 1'b0; a = 24'hABCDEF; b = 24'h123456; op = 3'b111;

        // DIVU then ADD launched from the FIN cycle with no bubble.
        issue("divu_b2b", 3'b111, 24'h000064, 24'h00000A, 24'h00000A, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("add_b2b",  3'b010, 24'hFFFFFF, 24'h000001, 24'h000000, 24'h0, 1'b1, 1'b0, 1'b1, 1'b0);

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
